uart_tx: RTL and testbench
==========================

# uart_tx

Frame serializer for the UART transmit path: accepts a byte from the host side over a valid/ready handshake and shifts it out on `uart_txd` as start bit, 5–8 data bits (LSB first), optional parity and 1–2 stop bits. Bit timing comes from the shared baud generator's oversample pulse `pls_tx`: one bit lasts `osm` pulses, the same oversampling ratio the receiver uses. It sits alongside the receiver in the UART top and is driven by the same `uart_config` frame settings.

## Interface
- No parameters. Frame format comes from `ucfg`; bit length comes from `osm`.
- `clk  in  1` — system clock.
- `rstn  in  1` — asynchronous, active-low reset.
- `pls_tx  in  1` — oversample tick from the baud generator, single-cycle pulse.
- `ucfg  in  uart_config` — fields used:
  - `data_len`: legal range 5..8.
  - `stop_len`: legal range 1..2.
  - `parity_en`.
  - `parity_even`.
- `osm  in  5` — `pls_tx` ticks per bit; legal range 1..31.
- `tdr  in  8` — byte to send. Only bits `[data_len-1:0]` are transmitted.
- `valid_tx  in  1` — host offers `tdr`.
- `ready_tx  out  1` — block can accept. High only in IDLE.
- `uart_txd  out  1` — serial line, registered, idle high.
- `busy_tx  out  1` — frame in progress (state != IDLE).
- `en_txcnt  out  1` — enables the baud generator; equals `busy_tx`.
- `done_tx  out  1` — one-cycle pulse when the last stop bit completes.

## Operation
- **Handshake.** Transfer occurs on a rising edge with `valid_tx && ready_tx`. On that edge the block:
  - copies `tdr` into shift register `tsr`;
  - snapshots `ucfg` and `osm` (later changes are ignored until the next accept);
  - clears `tick_cnt` and `bitcnt`;
  - goes to START.
  - `valid_tx` while busy is ignored; `tdr` is not sampled.
- **`tick_cnt` (5 bits).** Advances on each `pls_tx` while not IDLE. At `osm_s-1` it wraps to 0 instead of incrementing. A `pls_tx` at `tick_cnt==osm_s-1` is the bit-end event `bit_end`, which also drives all state transitions below.
- **States and outputs.**
  - IDLE: `txd=1`. On accept → START.
  - START: `txd=0`. On `bit_end` → DATA, `bitcnt=0`.
  - DATA: `txd=tsr[bitcnt]`. On `bit_end`:
    - if `bitcnt==data_len_s-1`, go to PARITY (if `parity_en_s`) else STOP, and set `bitcnt=0`;
    - otherwise `bitcnt+1`.
  - PARITY: `txd=par`. On `bit_end` → STOP, `bitcnt=0`.
  - STOP: `txd=1`. On `bit_end`:
    - if `bitcnt==stop_len_s-1`, go to IDLE and pulse `done_tx`;
    - otherwise `bitcnt+1`.
- **Parity.** `par = ^(tsr & mask(data_len_s))`, then inverted when `!parity_even_s`. Even parity therefore gives an even total count of ones over data plus parity.
- **Line output.** `uart_txd` is a register loaded with the next-state line value, so the line changes on the same edge as the state.
- **Illegal config values.** These are clamped at snapshot:
  - `osm` 0 → 1;
  - `data_len` <5 → 5, >8 → 8;
  - `stop_len` 0 → 1, >2 → 2.

## Timing
- **Reset values.**
  - `uart_txd=1`, `ready_tx=1`, `busy_tx=0`, `en_txcnt=0`, `done_tx=0`.
  - `tsr`, `tick_cnt` and `bitcnt` reset to 0; state resets to IDLE.
- **Accept latency.** Accept on edge N puts `uart_txd` low and `busy_tx` high after edge N. `ready_tx` is low from N.
- **Bit length.** Every bit, including START, lasts exactly `osm_s` `pls_tx` pulses counted after accept. A `pls_tx` in the same cycle as accept is not counted.
- **Frame length.** `(1 + data_len + parity_en + stop_len) × osm` ticks.
- **Frame end.** `done_tx` is high for the cycle after the final `bit_end` edge. `ready_tx` rises on that same edge.
- **Back-to-back.** A host holding `valid_tx` high gets the next accept on the edge after `done_tx` is seen. Minimum idle-high gap between frames is 1 clk.
- **Reset mid-frame.** `rstn` low forces `uart_txd=1` and IDLE immediately (asynchronously). No `done_tx` pulse is produced for the aborted frame.
- **`pls_tx` widths.** A `pls_tx` held high for k cycles counts as k ticks. The baud generator guarantees single-cycle pulses.

## Test plan
- **Basic 8N1 frame.** `ucfg`=8N1, `osm`=16, `pls_tx` every 4 clk, send 0xA5.
  - `uart_txd` sequence: 0,1,0,1,0,0,1,0,1,1.
  - Each bit lasts 64 clk.
  - `done_tx` pulses once, 640 clk after accept.
- **7E2 parity.** `data_len`=7, even parity, 2 stop bits, `osm`=4.
  - 0x03 → parity bit 0; 0x07 → parity bit 1.
  - Two stop bits, frame length 44 ticks.
- **Odd parity, 5 bits.** `data_len`=5, odd parity, send 0x1F → parity bit 0. Bits `[7:5]` of `tdr` never appear on the line.
- **Handshake.** Hold `valid_tx` high with 3 bytes queued.
  - Each byte is accepted exactly once, only while `ready_tx`=1.
  - Frames are separated by 1 idle-high clk.
  - Changing `tdr` or `ucfg` mid-frame does not alter the frame in flight.
- **Reset mid-frame.** Assert `rstn`=0 during DATA bit 3.
  - `uart_txd` returns to 1 without waiting for a clock edge; outputs take their reset values.
  - After release, the next frame is sent intact.
- **Edge cases.**
  - `osm`=1 with `pls_tx` every clk gives 1-clk bits.
  - `osm`=0 is clamped to 1 and behaves identically.
  - `pls_tx` coincident with accept is not counted.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared frame-format settings for the UART transmit and receive paths.
package uart_tx_pkg;

    typedef struct packed {
        logic [3:0] data_len;     // data bits per frame, 5..8
        logic [1:0] stop_len;     // stop bits per frame, 1..2
        logic       parity_en;    // append a parity bit after the data
        logic       parity_even;  // 1: even parity, 0: odd parity
    } uart_config;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake into the UART transmitter.
interface uart_tx_if;

    logic [7:0] tdr;
    logic       valid_tx;
    logic       ready_tx;

    modport master (output tdr, output valid_tx, input ready_tx);
    modport slave  (input tdr, input valid_tx, output ready_tx);

endinterface

// File: rtl/uart_tx.sv
// UART frame serializer: start bit, 5..8 data bits LSB first, optional parity,
// 1..2 stop bits, bit timing from the baud generator's oversample pulse.
module uart_tx
    import uart_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       pls_tx,
    input  uart_config ucfg,
    input  logic [4:0] osm,
    uart_tx_if.slave   host,
    output logic       uart_txd,
    output logic       busy_tx,
    output logic       en_txcnt,
    output logic       done_tx
);

    localparam int unsigned TICK_W = 5;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DLEN_W = 4;
    localparam int unsigned SLEN_W = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   tsr;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bitcnt;
    logic [TICK_W-1:0]   osm_s;
    logic [DLEN_W-1:0]   data_len_s;
    logic [SLEN_W-1:0]   stop_len_s;
    logic                parity_en_s;
    logic                parity_even_s;
    logic                ready_r;

    logic [TICK_W-1:0]   osm_c;
    logic [DLEN_W-1:0]   data_len_c;
    logic [SLEN_W-1:0]   stop_len_c;
    logic [BYTE_W-1:0]   mask_c;
    logic                par_c;
    logic                bit_end_c;
    logic                last_data_c;
    logic                last_stop_c;
    logic [BIT_W-1:0]    next_bit_c;

    assign host.ready_tx = ready_r;
    assign en_txcnt      = busy_tx;

    // Clamp illegal frame settings before they are snapshotted on accept.
    always_comb begin
        osm_c      = osm;
        data_len_c = ucfg.data_len;
        stop_len_c = ucfg.stop_len;
        if (osm == TICK_W'(0))
            osm_c = TICK_W'(1);
        if (ucfg.data_len < DLEN_W'(5))
            data_len_c = DLEN_W'(5);
        else if (ucfg.data_len > DLEN_W'(8))
            data_len_c = DLEN_W'(8);
        if (ucfg.stop_len == SLEN_W'(0))
            stop_len_c = SLEN_W'(1);
        else if (ucfg.stop_len > SLEN_W'(2))
            stop_len_c = SLEN_W'(2);
    end

    // Bit-end strobe, parity over the active data bits and bit-count limits.
    always_comb begin
        mask_c      = BYTE_W'(8'hFF) >> (DLEN_W'(8) - data_len_s);
        par_c       = (^(tsr & mask_c)) ^ ~parity_even_s;
        bit_end_c   = (state != S_IDLE) && pls_tx && (tick_cnt == osm_s - TICK_W'(1));
        last_data_c = (bitcnt == BIT_W'(data_len_s - DLEN_W'(1)));
        last_stop_c = (bitcnt == BIT_W'(stop_len_s - SLEN_W'(1)));
        next_bit_c  = bitcnt + BIT_W'(1);
    end

    // Frame sequencer; the line register is loaded with the next state's bit value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            tsr           <= '0;
            tick_cnt      <= '0;
            bitcnt        <= '0;
            osm_s         <= TICK_W'(1);
            data_len_s    <= DLEN_W'(8);
            stop_len_s    <= SLEN_W'(1);
            parity_en_s   <= 1'b0;
            parity_even_s <= 1'b0;
            ready_r       <= 1'b1;
            busy_tx       <= 1'b0;
            done_tx       <= 1'b0;
            uart_txd      <= 1'b1;
        end else begin
            done_tx <= 1'b0;

            if ((state != S_IDLE) && pls_tx)
                tick_cnt <= (tick_cnt == osm_s - TICK_W'(1)) ? TICK_W'(0) : tick_cnt + TICK_W'(1);

            case (state)
                S_IDLE: begin
                    if (host.valid_tx && ready_r) begin
                        tsr           <= host.tdr;
                        osm_s         <= osm_c;
                        data_len_s    <= data_len_c;
                        stop_len_s    <= stop_len_c;
                        parity_en_s   <= ucfg.parity_en;
                        parity_even_s <= ucfg.parity_even;
                        tick_cnt      <= '0;
                        bitcnt        <= '0;
                        state         <= S_START;
                        uart_txd      <= 1'b0;
                        ready_r       <= 1'b0;
                        busy_tx       <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        state    <= S_DATA;
                        bitcnt   <= '0;
                        uart_txd <= tsr[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        if (last_data_c) begin
                            bitcnt <= '0;
                            if (parity_en_s) begin
                                state    <= S_PARITY;
                                uart_txd <= par_c;
                            end else begin
                                state    <= S_STOP;
                                uart_txd <= 1'b1;
                            end
                        end else begin
                            bitcnt   <= next_bit_c;
                            uart_txd <= tsr[next_bit_c];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state    <= S_STOP;
                        bitcnt   <= '0;
                        uart_txd <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        if (last_stop_c) begin
                            state   <= S_IDLE;
                            done_tx <= 1'b1;
                            ready_r <= 1'b1;
                            busy_tx <= 1'b0;
                        end else begin
                            bitcnt <= next_bit_c;
                        end
                        uart_txd <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    uart_txd <= 1'b1;
                    ready_r  <= 1'b1;
                    busy_tx  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues the expected frame on each
// accept, a monitor follows the line tick by tick and compares whole frames.
module tb_uart_tx;
    import uart_tx_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [3:0] dlen;
        logic [1:0] slen;
        logic       pen;
        logic       peven;
        logic [4:0] osm;
        logic       par;    // hand-computed parity bit
    } vec_t;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          osm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pls_tx = 1'b0;
    uart_config ucfg;
    logic [4:0] osm;
    logic       uart_txd;
    logic       busy_tx;
    logic       en_txcnt;
    logic       done_tx;

    uart_tx_if bus();

    uart_tx u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .pls_tx   (pls_tx),
        .ucfg     (ucfg),
        .osm      (osm),
        .host     (bus),
        .uart_txd (uart_txd),
        .busy_tx  (busy_tx),
        .en_txcnt (en_txcnt),
        .done_tx  (done_tx)
    );

    int   checks = 0;
    int   failures = 0;
    int   pushes = 0;
    int   frames_done = 0;
    exp_t sb[$];

    int   pls_period = 4;
    int   pcnt = 0;

    always #5 clk = ~clk;

    // Oversample tick generator: one-cycle pulse every pls_period clocks.
    always begin
        @(posedge clk);
        #1;
        if (pcnt >= pls_period - 1) begin
            pcnt   = 0;
            pls_tx = 1'b1;
        end else begin
            pcnt   = pcnt + 1;
            pls_tx = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t build(input vec_t v);
        exp_t e;
        int   dl;
        int   sl;
        int   n;
        dl = (v.dlen < 4'd5) ? 5 : (v.dlen > 4'd8) ? 8 : int'(v.dlen);
        sl = (v.slen == 2'd0) ? 1 : (v.slen > 2'd2) ? 2 : int'(v.slen);
        e.osm  = (v.osm == 5'd0) ? 1 : int'(v.osm);
        e.bits = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < dl; i++)
            e.bits[1 + i] = v.data[i];
        n = 1 + dl;
        if (v.pen) begin
            e.bits[n] = v.par;
            n = n + 1;
        end
        e.nbits = n + sl;
        return e;
    endfunction

    // Monitor: follows the line per consumed tick and checks each frame and its done pulse.
    logic        mon_busy = 1'b0;
    logic        stray = 1'b0;
    exp_t        cur;
    int          t = 0;
    int          idx = 0;
    logic [11:0] cap;
    logic        done_early;
    logic        en_bad;

    always @(negedge clk) begin
        if (!rstn) begin
            mon_busy = 1'b0;
            stray    = 1'b0;
            sb.delete();
        end else begin
            if (!mon_busy) begin
                if (done_tx)
                    check("spurious_done", 32'(done_tx), 32'd0);
                if (stray) begin
                    if (uart_txd)
                        stray = 1'b0;
                end else if (!uart_txd) begin
                    check("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        cur        = sb.pop_front();
                        cap        = cur.bits;
                        done_early = 1'b0;
                        en_bad     = 1'b0;
                        t          = 0;
                        mon_busy   = 1'b1;
                    end else begin
                        stray = 1'b1;
                    end
                end
            end
            if (mon_busy) begin
                idx = t / cur.osm;
                if (busy_tx !== en_txcnt)
                    en_bad = 1'b1;
                if (idx < cur.nbits) begin
                    if (uart_txd !== cur.bits[idx])
                        cap[idx] = uart_txd;
                    if (done_tx)
                        done_early = 1'b1;
                    if (pls_tx)
                        t = t + 1;
                end else begin
                    check("frame_bits", 32'(cap), 32'(cur.bits));
                    check("frame_end", 32'({done_early, done_tx, uart_txd, busy_tx}), 32'(4'b0110));
                    check("en_eq_busy", 32'(en_bad), 32'd0);
                    frames_done = frames_done + 1;
                    mon_busy    = 1'b0;
                end
            end
        end
    end

    // Present v (valid already high) and wait for the accept edge.
    task automatic offer(input vec_t v);
        int n;
        ucfg.data_len    = v.dlen;
        ucfg.stop_len    = v.slen;
        ucfg.parity_en   = v.pen;
        ucfg.parity_even = v.peven;
        osm              = v.osm;
        bus.tdr          = v.data;
        bus.valid_tx     = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.ready_tx && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!bus.ready_tx) begin
            check("accept_timeout", 32'(bus.ready_tx), 32'd1);
        end else begin
            sb.push_back(build(v));
            pushes = pushes + 1;
            @(posedge clk);
            #1;
            check("ready_low_after_accept", 32'(bus.ready_tx), 32'd0);
        end
    endtask

    task automatic send(input vec_t v);
        offer(v);
        bus.valid_tx = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(sb.size() == 0 && !mon_busy && bus.ready_tx)) begin
            @(negedge clk);
            n = n + 1;
        end
        check("idle_timeout", 32'(n >= budget), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t v;

    initial begin
        bus.valid_tx = 1'b0;
        bus.tdr      = 8'h00;
        ucfg         = '{data_len: 4'd8, stop_len: 2'd1, parity_en: 1'b0, parity_even: 1'b0};
        osm          = 5'd16;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd",   32'(uart_txd),     32'd1);
        check("rst_ready", 32'(bus.ready_tx), 32'd1);
        check("rst_busy",  32'(busy_tx),      32'd0);
        check("rst_en",    32'(en_txcnt),     32'd0);
        check("rst_done",  32'(done_tx),      32'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, osm 16, tick every 4 clk: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        pls_period = 4;
        v = '{data: 8'hA5, dlen: 4'd8, slen: 2'd1, pen: 1'b0, peven: 1'b0, osm: 5'd16, par: 1'b0};
        send(v);
        wait_idle(2000);

        // 7E2, osm 4
        pls_period = 2;
        v = '{data: 8'h03, dlen: 4'd7, slen: 2'd2, pen: 1'b1, peven: 1'b1, osm: 5'd4, par: 1'b0};
        send(v);
        wait_idle(1000);
        v = '{data: 8'h07, dlen: 4'd7, slen: 2'd2, pen: 1'b1, peven: 1'b1, osm: 5'd4, par: 1'b1};
        send(v);
        wait_idle(1000);

        // 5O1: upper tdr bits never reach the line
        v = '{data: 8'h1F, dlen: 4'd5, slen: 2'd1, pen: 1'b1, peven: 1'b0, osm: 5'd4, par: 1'b0};
        send(v);
        wait_idle(1000);
        v = '{data: 8'hFF, dlen: 4'd5, slen: 2'd1, pen: 1'b1, peven: 1'b0, osm: 5'd4, par: 1'b0};
        send(v);
        wait_idle(1000);

        // Clamped config: data_len 3 -> 5, stop_len 3 -> 2; 0x2A low 5 bits have two ones
        v = '{data: 8'h2A, dlen: 4'd3, slen: 2'd3, pen: 1'b1, peven: 1'b1, osm: 5'd2, par: 1'b0};
        send(v);
        wait_idle(1000);

        // Back-to-back with valid held; tdr/ucfg change while the previous frame is in flight
        v = '{data: 8'h3C, dlen: 4'd8, slen: 2'd1, pen: 1'b0, peven: 1'b0, osm: 5'd3, par: 1'b0};
        offer(v);
        v = '{data: 8'hC3, dlen: 4'd8, slen: 2'd1, pen: 1'b1, peven: 1'b1, osm: 5'd3, par: 1'b0};
        offer(v);
        v = '{data: 8'h5B, dlen: 4'd6, slen: 2'd1, pen: 1'b1, peven: 1'b0, osm: 5'd3, par: 1'b1};
        offer(v);
        bus.valid_tx = 1'b0;
        wait_idle(2000);

        // Reset during data bit 3 (8 clk per bit): async return to idle, no done pulse
        v = '{data: 8'h55, dlen: 4'd8, slen: 2'd1, pen: 1'b0, peven: 1'b0, osm: 5'd4, par: 1'b0};
        send(v);
        repeat (36) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_txd",   32'(uart_txd),     32'd1);
        check("midrst_ready", 32'(bus.ready_tx), 32'd1);
        check("midrst_busy",  32'(busy_tx),      32'd0);
        check("midrst_done",  32'(done_tx),      32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (80) @(posedge clk);
        #1;

        // Next frame after reset is intact: 8O2, 0x96 has four ones
        v = '{data: 8'h96, dlen: 4'd8, slen: 2'd2, pen: 1'b1, peven: 1'b0, osm: 5'd4, par: 1'b1};
        send(v);
        wait_idle(1000);

        // osm 1 with tick every clk (tick coincides with accept), then osm 0 clamped to 1
        pls_period = 1;
        v = '{data: 8'h81, dlen: 4'd8, slen: 2'd1, pen: 1'b0, peven: 1'b0, osm: 5'd1, par: 1'b0};
        send(v);
        wait_idle(200);
        v = '{data: 8'h81, dlen: 4'd8, slen: 2'd1, pen: 1'b0, peven: 1'b0, osm: 5'd0, par: 1'b0};
        send(v);
        wait_idle(200);

        // Every accepted frame except the aborted one was seen exactly once
        check("frames_seen", 32'(frames_done), 32'(pushes - 1));
        check("queue_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
